// File: rtl/traffic_lights_xn.sv
// Round-robin N-approach intersection controller: RY/G/blink/Y per approach, all-red clearance, off and uncontrolled modes.
// Optional status ports cur_dir_o/phase_o are enabled by defining TRAFFIC_LIGHTS_XN_STATUS_EN.
module traffic_lights_xn #(
   parameter int unsigned NUM_DIR              = 4,
   parameter int unsigned TIME_W               = 16,
   parameter int unsigned BLINK_HALF_PERIOD    = 500,
   parameter int unsigned GREEN_BLINKS_NUM     = 4,
   parameter int unsigned RED_YELLOW_TIME      = 3000,
   parameter int unsigned GREEN_TIME_DEFAULT   = 8000,
   parameter int unsigned YELLOW_TIME_DEFAULT  = 3000,
   parameter int unsigned ALL_RED_TIME_DEFAULT = 1000
) (
   input  logic                       clk_i,
   input  logic                       srst_i,
   input  logic [2:0]                 cmd_type_i,
   input  logic                       cmd_valid_i,
   input  logic [$clog2(NUM_DIR)-1:0] cmd_dir_i,
   input  logic [TIME_W-1:0]          cmd_data_i,
   output logic [NUM_DIR-1:0]         red_o,
   output logic [NUM_DIR-1:0]         yellow_o,
   output logic [NUM_DIR-1:0]         green_o
`ifdef TRAFFIC_LIGHTS_XN_STATUS_EN
   ,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir_o,
   output logic [2:0]                 phase_o
`endif
);

   localparam int unsigned DIR_W  = $clog2(NUM_DIR);
   localparam int unsigned HALVES = 2 * GREEN_BLINKS_NUM;
   localparam int unsigned HALF_W = (HALVES > 1) ? $clog2(HALVES) : 1;

   localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(HALVES - 1);
   localparam logic [TIME_W-1:0] BLINK_LOAD = (BLINK_HALF_PERIOD == 0) ? '0 : TIME_W'(BLINK_HALF_PERIOD - 1);
   localparam logic [TIME_W-1:0] RY_LOAD    = (RED_YELLOW_TIME == 0) ? '0 : TIME_W'(RED_YELLOW_TIME - 1);
   localparam logic [TIME_W-1:0] GREEN_DEF  = TIME_W'(GREEN_TIME_DEFAULT);
   localparam logic [TIME_W-1:0] YELLOW_DEF = TIME_W'(YELLOW_TIME_DEFAULT);
   localparam logic [TIME_W-1:0] AR_DEF     = TIME_W'(ALL_RED_TIME_DEFAULT);

   typedef enum logic [2:0] {
      ST_ALL_RED     = 3'd0,
      ST_RED_YELLOW  = 3'd1,
      ST_GREEN       = 3'd2,
      ST_GREEN_BLINK = 3'd3,
      ST_YELLOW      = 3'd4,
      ST_OFF         = 3'd5,
      ST_UNC_ON      = 3'd6,
      ST_UNC_OFF     = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CMD_TURN_ON     = 3'd0,
      CMD_TURN_OFF    = 3'd1,
      CMD_SET_UNC     = 3'd2,
      CMD_SET_GREEN   = 3'd3,
      CMD_SET_YELLOW  = 3'd4,
      CMD_SET_ALL_RED = 3'd5,
      CMD_SET_DIR_EN  = 3'd6,
      CMD_NOP         = 3'd7
   } cmd_t;

   state_t              r_state, w_state;
   logic [DIR_W-1:0]    r_dir, w_dir;
   logic                r_first, w_first;
   logic [TIME_W-1:0]   r_cnt, w_cnt;
   logic [HALF_W-1:0]   r_half, w_half;
   logic [TIME_W-1:0]   r_green_time [NUM_DIR];
   logic [TIME_W-1:0]   w_green_time [NUM_DIR];
   logic [TIME_W-1:0]   r_yellow_time, w_yellow_time;
   logic [TIME_W-1:0]   r_all_red_time, w_all_red_time;
   logic [NUM_DIR-1:0]  r_dir_en, w_dir_en;
   logic [NUM_DIR-1:0]  r_red, r_yellow, r_green;
   logic [NUM_DIR-1:0]  w_red, w_yellow, w_green, w_onehot;
   logic                w_found;
   logic [DIR_W-1:0]    w_next_dir;
   logic                w_dir_ok;
   int unsigned         w_cand;

   // A time of 0 is treated as 1 cycle.
   function automatic logic [TIME_W-1:0] f_load(input logic [TIME_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Next enabled approach: from 0 after reset/TURN_ON, otherwise strictly after the current one (wrapping to itself).
   always_comb begin
      w_found    = 1'b0;
      w_next_dir = '0;
      w_cand     = 0;
      for (int unsigned i = 0; i < NUM_DIR; i++) begin
         w_cand = (r_first ? 0 : int'(r_dir) + 1) + i;
         if (w_cand >= NUM_DIR) w_cand = w_cand - NUM_DIR;
         if (!w_found && r_dir_en[DIR_W'(w_cand)]) begin
            w_found    = 1'b1;
            w_next_dir = DIR_W'(w_cand);
         end
      end
   end

   always_comb begin
      w_state        = r_state;
      w_dir          = r_dir;
      w_first        = r_first;
      w_cnt          = r_cnt;
      w_half         = r_half;
      w_green_time   = r_green_time;
      w_yellow_time  = r_yellow_time;
      w_all_red_time = r_all_red_time;
      w_dir_en       = r_dir_en;
      w_dir_ok       = int'(cmd_dir_i) < NUM_DIR;

      if (r_cnt != '0) begin
         if (r_state != ST_OFF) w_cnt = r_cnt - 1'b1;
      end else begin
         case (r_state)
            ST_ALL_RED: begin
               if (w_found) begin
                  w_state = ST_RED_YELLOW;
                  w_dir   = w_next_dir;
                  w_first = 1'b0;
                  w_cnt   = RY_LOAD;
               end else begin
                  w_cnt = f_load(r_all_red_time);
               end
            end
            ST_RED_YELLOW: begin
               w_state = ST_GREEN;
               w_cnt   = f_load(r_green_time[r_dir]);
            end
            ST_GREEN: begin
               w_state = ST_GREEN_BLINK;
               w_cnt   = BLINK_LOAD;
               w_half  = HALF_LOAD;
            end
            ST_GREEN_BLINK: begin
               if (r_half == '0) begin
                  w_state = ST_YELLOW;
                  w_cnt   = f_load(r_yellow_time);
               end else begin
                  w_half = r_half - 1'b1;
                  w_cnt  = BLINK_LOAD;
               end
            end
            ST_YELLOW: begin
               w_state = ST_ALL_RED;
               w_cnt   = f_load(r_all_red_time);
            end
            ST_UNC_ON: begin
               w_state = ST_UNC_OFF;
               w_cnt   = BLINK_LOAD;
            end
            ST_UNC_OFF: begin
               w_state = ST_UNC_ON;
               w_cnt   = BLINK_LOAD;
            end
            default: ;
         endcase
      end

      // Mode commands are applied after the timed transition so they take precedence.
      if (cmd_valid_i) begin
         case (cmd_t'(cmd_type_i))
            CMD_TURN_ON: begin
               w_state = ST_ALL_RED;
               w_dir   = '0;
               w_first = 1'b1;
               if (r_state == ST_OFF) begin
                  for (int unsigned i = 0; i < NUM_DIR; i++) w_green_time[i] = GREEN_DEF;
                  w_yellow_time  = YELLOW_DEF;
                  w_all_red_time = AR_DEF;
                  w_dir_en       = '1;
                  w_cnt          = f_load(AR_DEF);
               end else begin
                  w_cnt = f_load(r_all_red_time);
               end
            end
            CMD_TURN_OFF: begin
               w_state = ST_OFF;
               w_cnt   = '0;
            end
            CMD_SET_UNC: begin
               w_state = ST_UNC_ON;
               w_cnt   = BLINK_LOAD;
            end
            CMD_SET_GREEN:   if (w_dir_ok) w_green_time[cmd_dir_i] = cmd_data_i;
            CMD_SET_YELLOW:  w_yellow_time = cmd_data_i;
            CMD_SET_ALL_RED: w_all_red_time = cmd_data_i;
            CMD_SET_DIR_EN:  if (w_dir_ok) w_dir_en[cmd_dir_i] = cmd_data_i[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      w_onehot = {{(NUM_DIR-1){1'b0}}, 1'b1} << w_dir;
      w_red    = '0;
      w_yellow = '0;
      w_green  = '0;
      case (w_state)
         ST_ALL_RED:     w_red = '1;
         ST_RED_YELLOW: begin
            w_red    = '1;
            w_yellow = w_onehot;
         end
         ST_GREEN: begin
            w_red   = ~w_onehot;
            w_green = w_onehot;
         end
         ST_GREEN_BLINK: begin
            w_red   = ~w_onehot;
            w_green = w_half[0] ? '0 : w_onehot;
         end
         ST_YELLOW: begin
            w_red    = ~w_onehot;
            w_yellow = w_onehot;
         end
         ST_UNC_ON:      w_yellow = '1;
         default: ;
      endcase
   end

   // Lamps are registered from the next-state decode, so they track r_state with no extra delay.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         r_state        <= ST_ALL_RED;
         r_dir          <= '0;
         r_first        <= 1'b1;
         r_cnt          <= f_load(AR_DEF);
         r_half         <= '0;
         for (int unsigned i = 0; i < NUM_DIR; i++) r_green_time[i] <= GREEN_DEF;
         r_yellow_time  <= YELLOW_DEF;
         r_all_red_time <= AR_DEF;
         r_dir_en       <= '1;
         r_red          <= '1;
         r_yellow       <= '0;
         r_green        <= '0;
      end else begin
         r_state        <= w_state;
         r_dir          <= w_dir;
         r_first        <= w_first;
         r_cnt          <= w_cnt;
         r_half         <= w_half;
         r_green_time   <= w_green_time;
         r_yellow_time  <= w_yellow_time;
         r_all_red_time <= w_all_red_time;
         r_dir_en       <= w_dir_en;
         r_red          <= w_red;
         r_yellow       <= w_yellow;
         r_green        <= w_green;
      end
   end

   assign red_o    = r_red;
   assign yellow_o = r_yellow;
   assign green_o  = r_green;

`ifdef TRAFFIC_LIGHTS_XN_STATUS_EN
   logic [2:0] r_phase;

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) r_phase <= '0;
      else        r_phase <= (w_state == ST_UNC_OFF) ? 3'd6 : w_state;
   end

   assign cur_dir_o = r_dir;
   assign phase_o   = r_phase;
`endif

endmodule

// File: tb/tb_traffic_lights_xn.sv
// Directed self-checking bench for traffic_lights_xn with 3 approaches and short timings.
module tb_traffic_lights_xn;

   localparam logic [2:0] C_TURN_ON  = 3'd0;
   localparam logic [2:0] C_TURN_OFF = 3'd1;
   localparam logic [2:0] C_SET_UNC  = 3'd2;
   localparam logic [2:0] C_SET_GRN  = 3'd3;
   localparam logic [2:0] C_SET_YEL  = 3'd4;
   localparam logic [2:0] C_SET_AR   = 3'd5;
   localparam logic [2:0] C_SET_EN   = 3'd6;

   logic        clk_i = 1'b0;
   logic        srst_i;
   logic [2:0]  cmd_type_i;
   logic        cmd_valid_i;
   logic [1:0]  cmd_dir_i;
   logic [15:0] cmd_data_i;
   logic [2:0]  red_o, yellow_o, green_o;
`ifdef TRAFFIC_LIGHTS_XN_STATUS_EN
   logic [1:0]  cur_dir_o;
   logic [2:0]  phase_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   traffic_lights_xn #(
      .NUM_DIR(3), .TIME_W(16), .BLINK_HALF_PERIOD(2), .GREEN_BLINKS_NUM(2),
      .RED_YELLOW_TIME(3), .GREEN_TIME_DEFAULT(5), .YELLOW_TIME_DEFAULT(3),
      .ALL_RED_TIME_DEFAULT(2)
   ) dut (
      .clk_i(clk_i), .srst_i(srst_i),
      .cmd_type_i(cmd_type_i), .cmd_valid_i(cmd_valid_i),
      .cmd_dir_i(cmd_dir_i), .cmd_data_i(cmd_data_i),
      .red_o(red_o), .yellow_o(yellow_o), .green_o(green_o)
`ifdef TRAFFIC_LIGHTS_XN_STATUS_EN
      , .cur_dir_o(cur_dir_o), .phase_o(phase_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Expected {red, yellow, green}: 0 all-red, 1 red-yellow, 2 green, 3 blink-off, 4 yellow, 5 off, 6 unc-on.
   function automatic logic [8:0] lamps(input int code, input int dir);
      logic [2:0] oh;
      oh = 3'b001 << dir;
      case (code)
         0:       return {3'b111, 3'b000, 3'b000};
         1:       return {3'b111, oh,     3'b000};
         2:       return {~oh,    3'b000, oh};
         3:       return {~oh,    3'b000, 3'b000};
         4:       return {~oh,    oh,     3'b000};
         6:       return {3'b000, 3'b111, 3'b000};
         default: return 9'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_n(input string tag, input logic [8:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, {red_o, yellow_o, green_o}, exp);
         @(negedge clk_i);
      end
   endtask

   task automatic send_cmd(input logic [2:0] t, input logic [1:0] d, input logic [15:0] v);
      cmd_type_i  = t;
      cmd_dir_i   = d;
      cmd_data_i  = v;
      cmd_valid_i = 1'b1;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   // One full phase of approach dir starting at its first red-yellow cycle; optional command on the first green cycle.
   task automatic phase_seq(input int dir, input int g, input int y, input int ar,
                            input logic cmd_en = 1'b0, input logic [2:0] ct = 3'd7,
                            input logic [1:0] cd = 2'd0, input logic [15:0] cv = 16'd0);
      expect_n("red_yellow", lamps(1, dir), 3);
      for (int i = 0; i < g; i++) begin
         check("green", {red_o, yellow_o, green_o}, lamps(2, dir));
         if (i == 0 && cmd_en) begin
            cmd_type_i  = ct;
            cmd_dir_i   = cd;
            cmd_data_i  = cv;
            cmd_valid_i = 1'b1;
         end
         @(negedge clk_i);
         cmd_valid_i = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         check("blink", {red_o, yellow_o, green_o}, lamps(((i / 2) % 2) == 1 ? 2 : 3, dir));
         @(negedge clk_i);
      end
      expect_n("yellow", lamps(4, dir), y);
      expect_n("all_red", lamps(0, 0), ar);
   endtask

   initial begin
      srst_i      = 1'b1;
      cmd_type_i  = 3'd7;
      cmd_valid_i = 1'b0;
      cmd_dir_i   = 2'd0;
      cmd_data_i  = 16'd0;
      repeat (2) @(negedge clk_i);
      check("reset_lamps", {red_o, yellow_o, green_o}, lamps(0, 0));
      srst_i = 1'b0;

      // Basic rotation 0,1,2,0.
      expect_n("init_all_red", lamps(0, 0), 2);
      phase_seq(0, 5, 3, 2);
      phase_seq(1, 5, 3, 2);
      phase_seq(2, 5, 3, 2);

      // Green time writes take effect on the next entry; 0 behaves as 1.
      phase_seq(0, 5, 3, 2, 1'b1, C_SET_GRN, 2'd1, 16'd9);
      phase_seq(1, 9, 3, 2, 1'b1, C_SET_GRN, 2'd2, 16'd0);
      phase_seq(2, 1, 3, 2);

      // Skip disabled approach, sole approach reselected, none enabled holds all-red.
      phase_seq(0, 5, 3, 2, 1'b1, C_SET_EN, 2'd1, 16'd0);
      phase_seq(2, 1, 3, 2);
      phase_seq(0, 5, 3, 2);
      phase_seq(2, 1, 3, 2);
      phase_seq(0, 5, 3, 2, 1'b1, C_SET_EN, 2'd2, 16'd0);
      phase_seq(0, 5, 3, 2, 1'b1, C_SET_EN, 2'd0, 16'd0);
      expect_n("hold_all_red", lamps(0, 0), 10);
      send_cmd(C_SET_EN, 2'd2, 16'd1);
      expect_n("wait_expiry", lamps(0, 0), 1);
      phase_seq(2, 1, 3, 2);

      // Uncontrolled blink overriding a scheduled transition, off, power-on reload.
      expect_n("ry_dir2", lamps(1, 2), 3);
      check("green_dir2", {red_o, yellow_o, green_o}, lamps(2, 2));
      send_cmd(C_SET_UNC, 2'd0, 16'd0);
      expect_n("unc_on", lamps(6, 0), 2);
      expect_n("unc_off", lamps(5, 0), 2);
      expect_n("unc_on2", lamps(6, 0), 2);
      send_cmd(C_SET_YEL, 2'd0, 16'd6);
      send_cmd(C_TURN_OFF, 2'd0, 16'd0);
      expect_n("off", lamps(5, 0), 4);
      send_cmd(C_TURN_ON, 2'd0, 16'd0);
      expect_n("on_all_red", lamps(0, 0), 2);
      phase_seq(0, 5, 3, 2);
      phase_seq(1, 5, 6, 2, 1'b1, C_SET_YEL, 2'd0, 16'd6);
      phase_seq(2, 5, 6, 4, 1'b1, C_SET_AR, 2'd0, 16'd4);

      // TURN_ON while running restarts at dir0 but keeps programmed times.
      check("ry_before_on", {red_o, yellow_o, green_o}, lamps(1, 0));
      send_cmd(C_TURN_ON, 2'd0, 16'd0);
      expect_n("restart_all_red", lamps(0, 0), 4);
      phase_seq(0, 5, 6, 4);

      // Asynchronous reset mid-blink, then out-of-range direction commands.
      expect_n("ry_dir1", lamps(1, 1), 3);
      expect_n("green_dir1", lamps(2, 1), 5);
      expect_n("blink_dir1", lamps(3, 1), 2);
      check("blink_on_dir1", {red_o, yellow_o, green_o}, lamps(2, 1));
      #1 srst_i = 1'b1;
      #1 check("async_reset", {red_o, yellow_o, green_o}, lamps(0, 0));
      @(negedge clk_i);
      srst_i = 1'b0;
      check("post_reset", {red_o, yellow_o, green_o}, lamps(0, 0));
      send_cmd(C_SET_GRN, 2'd3, 16'd9);
      check("post_reset2", {red_o, yellow_o, green_o}, lamps(0, 0));
      send_cmd(C_SET_EN, 2'd3, 16'd0);
      phase_seq(0, 5, 3, 2);
      phase_seq(1, 5, 3, 2);
      phase_seq(2, 5, 3, 2);
      check("wrap_dir0", {red_o, yellow_o, green_o}, lamps(1, 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
